// File: rtl/footsies_input_pkg.sv
// -----------------------------------------------------------------------------
// footsies_input_pkg
//
// Shared definitions for the footsies per-player input front end.
//   DEFAULT_DEBOUNCE_CYCLES : clk cycles a synchronized level must hold before
//                             it is accepted (5 ms at 50 MHz)
//   DEFAULT_BUFFER_FRAMES   : frames a buffered attack press stays asserted
//   BUF_CNT_W               : width of the attack buffer frame counter
//   btn_t                   : bundle of the three player buttons, used for
//                             both the raw and the debounced button sets
// -----------------------------------------------------------------------------
package footsies_input_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_BUFFER_FRAMES   = 4;
    localparam int BUF_CNT_W               = 4;

    typedef struct packed {
        logic left;
        logic right;
        logic attack;
    } btn_t;

endpackage : footsies_input_pkg

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Two-flop synchronizer followed by a hold-time debouncer for one push button.
// A new synchronized level is accepted only after it has differed from the
// accepted level for DEBOUNCE_CYCLES consecutive clk cycles; any shorter
// excursion clears the counter and is discarded.
//
// Parameters:
//   DEBOUNCE_CYCLES : required hold time in clk cycles (minimum 2)
// Ports:
//   clk    in  1 : system clock
//   reset  in  1 : synchronous, active-high
//   raw    in  1 : asynchronous button level, active-high
//   stable out 1 : debounced level
// -----------------------------------------------------------------------------
module button_debouncer
    import footsies_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic [CNT_W-1:0] hold_cnt;

    // Synchronizer: the first flop may go metastable, only the second one is
    // used by the debounce logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
        end
    end

    // The counter measures how long sync_level has disagreed with stable.
    // It is cleared before it can pass CNT_LAST, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable   <= 1'b0;
            hold_cnt <= '0;
        end else if (sync_level == stable) begin
            hold_cnt <= '0;
        end else if (hold_cnt == CNT_LAST) begin
            stable   <= sync_level;
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

endmodule : button_debouncer

// File: rtl/footsies_input_conditioner.sv
// -----------------------------------------------------------------------------
// footsies_input_conditioner
//
// Per-player input front end sitting upstream of the player sprite state
// machine. Raw buttons are synchronized and debounced, opposing directions are
// cleaned to neutral, and left/right/attack are presented as registers that
// only change on the game frame tick.
//
// Build option:
//   FOOTSIES_INPUT_BUFFER_EN : when defined, an attack press is held for
//                              BUFFER_FRAMES frames (cancelled by attack_ack);
//                              when undefined, attack follows the debounced
//                              level plus any press seen since the last tick,
//                              and attack_ack is ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES : debounce hold time in clk cycles (minimum 2)
//   BUFFER_FRAMES   : frames of buffered attack per press (1..15)
// Ports:
//   clk            in  1 : system clock
//   reset          in  1 : synchronous, active-high
//   frame_tick     in  1 : one-cycle pulse per game frame
//   btn_left_raw   in  1 : asynchronous button, active-high
//   btn_right_raw  in  1 : asynchronous button, active-high
//   btn_attack_raw in  1 : asynchronous button, active-high
//   attack_ack     in  1 : consumer started an attack; used only on frame_tick
//   left           out 1 : frame-aligned move-back request
//   right          out 1 : frame-aligned move-forward request
//   attack         out 1 : frame-aligned attack request
//
// Handshake: there is no valid/ready pair here. frame_tick acts as the single
// qualifier for both directions: outputs are only meaningful in the cycle after
// a tick, and attack_ack is only looked at in a tick cycle.
// -----------------------------------------------------------------------------
module footsies_input_conditioner
    import footsies_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BUFFER_FRAMES   = DEFAULT_BUFFER_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_attack_raw,
    input  logic attack_ack,
    output logic left,
    output logic right,
    output logic attack
);

    btn_t raw_btn;
    btn_t db_btn;

    assign raw_btn.left   = btn_left_raw;
    assign raw_btn.right  = btn_right_raw;
    assign raw_btn.attack = btn_attack_raw;

    // -------------------------------------------------------------------------
    // Synchronize + debounce each button
    // -------------------------------------------------------------------------
    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_left (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_btn.left),
        .stable (db_btn.left)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_right (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_btn.right),
        .stable (db_btn.right)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_attack (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_btn.attack),
        .stable (db_btn.attack)
    );

    // -------------------------------------------------------------------------
    // Direction cleaning: both directions held resolves to neutral
    // -------------------------------------------------------------------------
    logic left_clean;
    logic right_clean;

    assign left_clean  = db_btn.left  & ~db_btn.right;
    assign right_clean = db_btn.right & ~db_btn.left;

    // -------------------------------------------------------------------------
    // Attack press latch
    // -------------------------------------------------------------------------
    logic attack_db_q;
    logic attack_rise;
    logic press_seen;
    logic press_now;

    assign attack_rise = db_btn.attack & ~attack_db_q;

    // A rise in the tick cycle itself is folded in before the latch clears,
    // so it still belongs to this tick.
    assign press_now = press_seen | attack_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            attack_db_q <= 1'b0;
            press_seen  <= 1'b0;
        end else begin
            attack_db_q <= db_btn.attack;
            if (frame_tick) begin
                press_seen <= 1'b0;
            end else if (attack_rise) begin
                press_seen <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Attack value loaded at the next tick
    // -------------------------------------------------------------------------
    logic attack_next;

`ifdef FOOTSIES_INPUT_BUFFER_EN
    localparam logic [BUF_CNT_W-1:0] BUF_LOAD = BUF_CNT_W'(BUFFER_FRAMES);

    logic [BUF_CNT_W-1:0] buf_cnt;
    logic [BUF_CNT_W-1:0] buf_cnt_next;

    // Priority: a fresh press reloads, otherwise an ack cancels, otherwise
    // the remaining frames count down.
    always_comb begin
        buf_cnt_next = buf_cnt;
        if (press_now) begin
            buf_cnt_next = BUF_LOAD;
        end else if (attack_ack) begin
            buf_cnt_next = '0;
        end else if (buf_cnt != '0) begin
            buf_cnt_next = buf_cnt - BUF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt <= '0;
        end else if (frame_tick) begin
            buf_cnt <= buf_cnt_next;
        end
    end

    // Using the post-update count makes the tick that loads the buffer the
    // first of exactly BUFFER_FRAMES asserted frames.
    assign attack_next = (buf_cnt_next != '0);
`else
    // Without buffering the level is used, and press_seen keeps a tap that
    // was pressed and released between two ticks visible for one frame.
    assign attack_next = db_btn.attack | press_now;

    logic unused_attack_ack;
    assign unused_attack_ack = attack_ack;

    localparam int unused_buffer_frames = BUFFER_FRAMES;
`endif

    // -------------------------------------------------------------------------
    // Frame-aligned output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            left   <= 1'b0;
            right  <= 1'b0;
            attack <= 1'b0;
        end else if (frame_tick) begin
            left   <= left_clean;
            right  <= right_clean;
            attack <= attack_next;
        end
    end

endmodule : footsies_input_conditioner

// File: tb/tb_footsies_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_footsies_input_conditioner
//
// Directed bench for footsies_input_conditioner with DEBOUNCE_CYCLES=4,
// BUFFER_FRAMES=3 and a frame tick every 20 clk cycles. Inputs are driven on
// the falling edge; outputs are sampled on the falling edge that follows the
// rising edge which consumed a tick. Expected {left,right,attack} per frame
// are hand-computed and queued in exp_q.
// Build option honoured: FOOTSIES_INPUT_BUFFER_EN.
// -----------------------------------------------------------------------------
module tb_footsies_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_attack_raw = 1'b0;
    logic attack_ack = 1'b0;
    logic left;
    logic right;
    logic attack;

    int total = 0;
    int bad = 0;
    int tick_phase = 0;
    logic [2:0] exp_q[$];

    footsies_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .BUFFER_FRAMES   (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .btn_left_raw   (btn_left_raw),
        .btn_right_raw  (btn_right_raw),
        .btn_attack_raw (btn_attack_raw),
        .attack_ack     (attack_ack),
        .left           (left),
        .right          (right),
        .attack         (attack)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got {l,r,a}=%b expected=%b", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One clk cycle; frame_tick is high for the cycle where tick_phase is 19.
    task automatic cycle();
        @(negedge clk);
        tick_phase = (tick_phase == 19) ? 0 : tick_phase + 1;
        frame_tick = (tick_phase == 19);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the next tick has been consumed by a rising edge.
    task automatic next_frame();
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (frame_tick) break;
        end
        cycle();
    endtask

    task automatic frame(input string tag, input logic [2:0] exp);
        exp_q.push_back(exp);
        next_frame();
        check(tag, {left, right, attack}, exp_q.pop_front());
    endtask

    // Hold reset for three edges with the given raw level, check outputs are
    // cleared, then release with a chosen tick phase. The first tick reaches
    // the DUT at edge (20 - ph) after release.
    task automatic do_reset(input logic v, input int ph);
        @(negedge clk);
        reset = 1'b1;
        frame_tick = 1'b0;
        attack_ack = 1'b0;
        btn_left_raw = v;
        btn_right_raw = v;
        btn_attack_raw = v;
        repeat (3) @(negedge clk);
        check("reset_out", {left, right, attack}, 3'b000);
        reset = 1'b0;
        tick_phase = ph;
        frame_tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with all buttons held; first tick at edge 5 precedes the end
        // of debounce (edge 6), second tick at edge 25 follows it.
        do_reset(1'b1, 15);
        frame("reset_early_tick", 3'b000);
        frame("reset_first_valid", 3'b001);
        frame("reset_second_valid", 3'b001);

        // 3-cycle glitch on left: ticks at edges 15 and 35.
        do_reset(1'b0, 5);
        btn_left_raw = 1'b1;
        wait_cycles(3);
        btn_left_raw = 1'b0;
        frame("glitch3_f1", 3'b000);
        frame("glitch3_f2", 3'b000);

        // 10-cycle pulse: debounced high over edges 7..16, tick at 15.
        do_reset(1'b0, 5);
        btn_left_raw = 1'b1;
        wait_cycles(10);
        btn_left_raw = 1'b0;
        frame("pulse10_f1", 3'b100);
        frame("pulse10_f2", 3'b000);

        // SOCD: ticks at edges 20, 40, 60.
        do_reset(1'b0, 0);
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        frame("socd_both", 3'b000);
        btn_right_raw = 1'b0;
        frame("socd_right_released", 3'b100);
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b1;
        frame("socd_right_only", 3'b010);

`ifdef FOOTSIES_INPUT_BUFFER_EN
        // Held press: three frames of attack, then none while still held.
        do_reset(1'b0, 0);
        btn_attack_raw = 1'b1;
        frame("buf_f1", 3'b001);
        frame("buf_f2", 3'b001);
        frame("buf_f3", 3'b001);
        frame("buf_held_f4", 3'b000);
        btn_attack_raw = 1'b0;
        wait_cycles(10);
        btn_attack_raw = 1'b1;
        frame("buf_repress_f1", 3'b001);
        frame("buf_repress_f2", 3'b001);
        frame("buf_repress_f3", 3'b001);
        frame("buf_repress_f4", 3'b000);

        // Ack on the second tick cancels; press and ack together reload.
        do_reset(1'b0, 0);
        btn_attack_raw = 1'b1;
        frame("ack_press", 3'b001);
        btn_attack_raw = 1'b0;
        attack_ack = 1'b1;
        frame("ack_cancel", 3'b000);
        btn_attack_raw = 1'b1;
        frame("ack_and_press", 3'b001);
        attack_ack = 1'b0;
        frame("ack_reload_f2", 3'b001);
        frame("ack_reload_f3", 3'b001);
        frame("ack_reload_f4", 3'b000);
`else
        // Tap pressed and released between ticks, ack held throughout.
        do_reset(1'b0, 0);
        attack_ack = 1'b1;
        wait_cycles(2);
        btn_attack_raw = 1'b1;
        wait_cycles(8);
        btn_attack_raw = 1'b0;
        frame("tap_seen", 3'b001);
        frame("tap_gone", 3'b000);
        btn_attack_raw = 1'b1;
        frame("level_f1_ack_ignored", 3'b001);
        frame("level_f2_ack_ignored", 3'b001);
        btn_attack_raw = 1'b0;
        frame("level_released", 3'b000);
`endif

        do_reset(1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_footsies_input_conditioner
